// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined subtractor, diff = A - B - bin, built from CLA half-word adders.
//
// Each stage adds one half-word as A + ~B + ~borrow on a carry-lookahead adder.
// The inverted carry-out is the borrow, and it ripples from stage 1 into stage 2.
// Both ends use a valid/ready handshake. A stalled output holds its values.
//
// Optional feature: define CLA_SUB_STATUS_EN to add the registered zero/ovf status outputs.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   A/B/bin are valid
//   in_ready   block can accept an operand set this cycle
//   A, B       minuend, subtrahend (DATA_WIDTH bits)
//   bin        borrow-in
//   out_valid  diff/bout are valid
//   out_ready  consumer accepts the result this cycle
//   diff       (A - B - bin) mod 2^DATA_WIDTH
//   bout       1 when A < B + bin (unsigned)
//   zero       diff == 0                        (CLA_SUB_STATUS_EN only)
//   ovf        signed overflow of A - B - bin   (CLA_SUB_STATUS_EN only)
module cla_sub_pipe #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bout
`ifdef CLA_SUB_STATUS_EN
    ,
    output logic                  zero,
    output logic                  ovf
`endif
);

    localparam int H = DATA_WIDTH / 2;

    // The result is H+1 bits wide, and its MSB is the carry-out.
    // Every carry comes from the generate/propagate terms.
    function automatic logic [H:0] cla_add(
        input logic [H-1:0] a,
        input logic [H-1:0] b,
        input logic         cin
    );
        logic [H-1:0] g;
        logic [H-1:0] p;
        logic [H:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < H; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[H], p ^ c[H-1:0]};
    endfunction

    logic                  r_s1_valid;
    logic [H-1:0]          r_s1_lo;
    logic                  r_s1_mid_borrow;
    logic [H-1:0]          r_s1_a_hi;
    logic [H-1:0]          r_s1_b_hi;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_diff;
    logic                  r_bout;

    logic                  w_s1_load;
    logic                  w_s2_load;
    logic [H:0]            w_s1_sum;
    logic [H:0]            w_s2_sum;
    logic [DATA_WIDTH-1:0] w_diff_next;

    // The stages can advance in the same cycle that the output drains.
    // So when out_ready is high, a full pipe still accepts a new operand set.
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

    // Subtraction is done as addition of the complement.
    // The carry-in is ~borrow, and the borrow-out is ~carry.
    assign w_s1_sum    = cla_add(A[H-1:0], ~B[H-1:0], ~bin);
    assign w_s2_sum    = cla_add(r_s1_a_hi, ~r_s1_b_hi, ~r_s1_mid_borrow);
    assign w_diff_next = {w_s2_sum[H-1:0], r_s1_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_lo         <= '0;
            r_s1_mid_borrow <= 1'b0;
            r_s1_a_hi       <= '0;
            r_s1_b_hi       <= '0;
        end else begin
            r_s1_valid <= w_s1_load ? 1'b1 : (w_s2_load ? 1'b0 : r_s1_valid);
            if (w_s1_load) begin
                r_s1_lo         <= w_s1_sum[H-1:0];
                r_s1_mid_borrow <= ~w_s1_sum[H];
                r_s1_a_hi       <= A[DATA_WIDTH-1:H];
                r_s1_b_hi       <= B[DATA_WIDTH-1:H];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_load ? 1'b1 : (out_ready ? 1'b0 : r_s2_valid);
            if (w_s2_load) begin
                r_diff <= w_diff_next;
                r_bout <= ~w_s2_sum[H];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;

`ifdef CLA_SUB_STATUS_EN
    logic r_zero;
    logic r_ovf;

    // Signed overflow can only occur when the operand signs differ.
    // It is flagged when the result sign no longer matches the minuend sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_load) begin
            r_zero <= (w_diff_next == '0);
            r_ovf  <= (r_s1_a_hi[H-1] != r_s1_b_hi[H-1]) &&
                      (w_diff_next[DATA_WIDTH-1] != r_s1_a_hi[H-1]);
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif

endmodule

// File: doc/cla_sub_pipe.md
# cla_sub_pipe

Two-stage pipelined subtractor built from carry-lookahead adder halves, with a valid/ready handshake on both sides. It computes diff = A − B − bin and a borrow-out. It is the subtract-direction companion to the combinational CLA adder, and is used wherever the datapath needs registered, back-pressurable subtraction. Internally, each stage evaluates one half-word as A + ~B + ~bin on a CLA, and the borrow ripples between the two stages.

## Interface
- DATA_WIDTH, 16, operand/result width; must be even and ≥ 4
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B/bin valid
- in_ready  output  1  block can accept an operand set this cycle
- A  input  DATA_WIDTH  minuend
- B  input  DATA_WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts result this cycle
- diff  output  DATA_WIDTH  (A − B − bin) mod 2^DATA_WIDTH
- bout  output  1  1 when A < B + bin (unsigned)
- zero  output  1  diff == 0 (only with CLA_SUB_STATUS_EN)
- ovf  output  1  signed overflow of A − B − bin (only with CLA_SUB_STATUS_EN)

## Operation
- H = DATA_WIDTH/2.
- Transfer at a port occurs on a rising edge where valid && ready.
- Stage 1 captures on input transfer:
  - low diff = A[H-1:0] + ~B[H-1:0] + ~bin, truncated to H bits
  - mid borrow = NOT carry-out of that sum
  - A[W-1:H], B[W-1:H]
  - s1_valid set
- Stage 2 captures from stage 1:
  - high diff = A_hi + ~B_hi + ~mid_borrow
  - bout = NOT carry-out of that sum
  - low diff passed through
  - s2_valid set
- Stage enables:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational; there is no combinational path from in_valid to out_valid.
- Valid flags:
  - s1_valid clears when s1 moves to s2 and no new input arrives.
  - s2_valid clears on output transfer when s1 is empty.
- out_valid = s2_valid. diff, bout and status outputs come directly from stage-2 registers.
- Stall: while out_valid && !out_ready, diff/bout/zero/ovf hold stable and are not overwritten.
- Results emerge in input order. Nothing is dropped or duplicated.
- Width rule: all intermediate sums are H+1 bits; the MSB is the carry.

## Timing
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, diff=0, bout=0, zero=0, ovf=0. in_ready=1 from the first cycle after reset.
- Latency: input transfer at edge N makes out_valid high after edge N+1. The result is available two edges after presentation.
- Throughput: one result per cycle with out_ready held high.
- Full: both stages valid and out_ready=0 drives in_ready=0 in the same cycle.
- Simultaneous events: input and output transfer on the same edge both complete; occupancy is unchanged.
- Reset mid-operation discards all in-flight data; no result is emitted for it.
- Inputs are sampled only on transfer edges; A/B/bin may change freely otherwise.

## Configuration
- Macro CLA_SUB_STATUS_EN.
- Defined:
  - zero and ovf ports exist and are registered in stage 2 alongside diff.
  - ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]). bin is included in the subtraction before the sign compare.
  - Both reset to 0.
- Undefined: the zero and ovf ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset, then A=0x0005, B=0x0003, bin=0, out_ready=1 -> two edges later: out_valid=1, diff=0x0002, bout=0; zero=0, ovf=0.
- A=0x0100, B=0x0001, bin=0 -> diff=0x00FF, bout=0 (borrow crosses the stage boundary). Then A=0x0000, B=0x0001 -> diff=0xFFFF, bout=1.
- A=0x1234, B=0x1234, bin=1 -> diff=0xFFFF, bout=1. With bin=0 -> diff=0x0000, bout=0, zero=1.
- Backpressure:
  - Stimulus: out_ready=0, in_valid held high with 3 operand sets.
  - Response: first two accepted, in_ready=0 on the third, diff stable while stalled.
  - Raise out_ready: results exit in order, third accepted on the same edge the first leaves.
- Status (macro defined): A=0x8000, B=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0. A=0x7FFF, B=0xFFFF -> diff=0x8000, ovf=1, bout=1.
- Reset mid-operation: assert rst_n=0 with both stages valid -> out_valid=0 immediately, diff=0. No stale result appears after release. 1000 random streams with random out_ready match a reference model of {bout, diff} = {1'b0, A} − B − bin.
